bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: digit geometry,
// the add-3 threshold, the controller state encoding and the helper used
// to check that DIGITS is wide enough for BIN_W.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Smallest number of decimal digits d with 10^d > 2^bin_w - 1.
  function automatic int bcd_digits_needed(input int bin_w);
    longint unsigned max_val;
    longint unsigned pow10;
    int              d;
    max_val = (64'd1 << bin_w) - 64'd1;
    pow10   = 64'd1;
    d       = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Add 3 within the digit; by construction the result never overflows 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      digit_out = digit_in + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on both sides and one conversion in flight.
// Optional feature: define BIN2BCD_EARLY_EXIT_EN to skip leading zero bits,
// so a conversion takes (index of highest set bit + 1) cycles instead of BIN_W.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 1 || BIN_W > 32 || DIGITS < bcd_digits_needed(BIN_W)) begin : g_param_err
    $error("bin_to_bcd_seq: BIN_W must be 1..32 and DIGITS must cover 2^BIN_W-1");
  end

  state_t             state;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   digits;
  logic [CNT_W-1:0]   count;

  logic [BCD_W-1:0]   adj_digits;
  logic [BCD_W-1:0]   next_digits;
  logic [CNT_W-1:0]   load_n;
  logic [BIN_W-1:0]   load_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adj_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits shift left by one, binary MSB enters digit 0 bit 0.
  assign next_digits = {adj_digits[BCD_W-2:0], shift_reg[BIN_W-1]};

`ifdef BIN2BCD_EARLY_EXIT_EN
  // Priority-encode the highest set bit and left-justify the operand so only significant bits are shifted.
  always_comb begin
    load_n = CNT_W'(1);
    for (int i = 0; i < BIN_W; i++) begin
      if (bin_in[i]) begin
        load_n = CNT_W'(i + 1);
      end
    end
    load_shift = bin_in << (BIN_W - int'(load_n));
  end
`else
  assign load_n     = CNT_W'(BIN_W);
  assign load_shift = bin_in;
`endif

  // Controller: accept in IDLE, iterate in SHIFT, hold the result in DONE until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      digits    <= '0;
      count     <= '0;
      bcd_out   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= load_shift;
            digits    <= '0;
            count     <= load_n;
            state     <= SHIFT;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          digits    <= next_digits;
          shift_reg <= shift_reg << 1;
          count     <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bcd_out   <= next_digits;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3). Expected
// results come from plain decimal arithmetic; expected latency from the
// bit length of the operand when BIN2BCD_EARLY_EXIT_EN is defined.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_out;
  logic        busy;

  int checks;
  int errors;
  int cycle;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Decimal digits of v, packed units-first.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'((v) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // Cycles from accept to result: full width, or bit length of v with early exit.
  function automatic int expected_latency(input int v);
`ifdef BIN2BCD_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (v >= (1 << i)) n = i + 1;
    end
    return n;
`else
    return 8;
`endif
  endfunction

  function automatic logic digits_ok(input logic [11:0] b);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (b[k*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full conversion with `hold` cycles of output backpressure.
  task automatic applyStimulus(input logic [7:0] value, input int hold);
    int cyc;
    logic [11:0] exp_bcd;
    exp_bcd = ref_bcd(int'(value));
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    bin_in    = value;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = 8'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("in_ready_shift", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(expected_latency(int'(value))));
    checkOutput("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    checkOutput("digit_range", 32'(digits_ok(bcd_out)), 32'd1);
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    bin_in   = 8'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_bcd", 32'(bcd_out), 32'(exp_bcd));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
    checkOutput("in_ready_back", 32'(in_ready), 32'd1);
    checkOutput("idle_not_busy", 32'(busy), 32'd0);
    checkOutput("idle_bcd_hold", 32'(bcd_out), 32'(exp_bcd));
  endtask

  initial begin
    int cyc;
    int prev_cycle;
    int prev_n;
    int b2b_vals [3];
    checks    = 0;
    errors    = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed conversions");
    applyStimulus(8'd255, 0);
    applyStimulus(8'd173, 5);
    applyStimulus(8'd5, 0);
    applyStimulus(8'd0, 0);
    applyStimulus(8'd128, 2);

    $display("[TB] back-to-back with in_valid held");
    b2b_vals   = '{0, 99, 100};
    prev_cycle = -1;
    prev_n     = 0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    foreach (b2b_vals[i]) begin
      bin_in = 8'(b2b_vals[i]);
      cyc = 0;
      while (!busy && cyc < 100) begin
        @(posedge clk); #1; cyc++;
      end
      checkOutput("b2b_accept", 32'(busy), 32'd1);
      if (prev_cycle >= 0) begin
        checkOutput("b2b_gap", 32'(cycle - prev_cycle), 32'(prev_n + 2));
      end
      prev_cycle = cycle;
      prev_n     = expected_latency(b2b_vals[i]);
      checkOutput("b2b_in_ready", 32'(in_ready), 32'd0);
      bin_in = 8'hAA;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
        @(posedge clk); #1; cyc++;
      end
      checkOutput("b2b_bcd", 32'(bcd_out), 32'(ref_bcd(b2b_vals[i])));
      checkOutput("b2b_in_ready_done", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("b2b_idle", 32'(in_ready), 32'd1);

    $display("[TB] asynchronous reset mid-conversion");
    bin_in   = 8'd200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_bcd", 32'(bcd_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'd42, 0);

    $display("[TB] exhaustive sweep with random backpressure");
    for (int v = 0; v < 256; v++) begin
      applyStimulus(8'(v), int'($urandom_range(0, 3)));
    end

    $display("[TB] random operands");
    for (int r = 0; r < 20; r++) begin
      applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
